// File: rtl/mandel_pkg.sv
// Shared widths, frame length, FSM encoding and colour constants for the Mandelbrot job host.
// Imported by the host and its colour-map helper.
package mandel_pkg;
    localparam int N_BIT     = 16;
    localparam int BIT_FRAC  = 12;
    localparam int FRAME_LEN = 10;

    localparam logic [1:0] COLOR_INSET = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_RECV,
        ST_DONE
    } state_t;
endpackage

// File: rtl/mandel_color_map.sv
// Maps a returned iteration count to a 2-bit framebuffer colour.
// Purely combinational, no backpressure.
module mandel_color_map
    import mandel_pkg::*;
#(
    parameter int MAX_ITER = 100
) (
    input  logic [7:0] iter_cnt,
    output logic [1:0] color
);
    localparam logic [7:0] MAX_ITER_B = 8'(MAX_ITER);

    // In-set points are black; a zero low pair would also be black, so it is bumped to 3.
    always_comb begin
        if (iter_cnt >= MAX_ITER_B) begin
            color = COLOR_INSET;
        end else if (iter_cnt[1:0] == 2'd0) begin
            color = 2'd3;
        end else begin
            color = iter_cnt[1:0];
        end
    end
endmodule

// File: rtl/mandel_job_host.sv
// Sends a 10-byte job frame to TX8, then turns returned counts into framebuffer writes (1 cycle after rx edge).
// Paced by tx_busy handshake; RECV waits for rx bytes, bounded only when RX_TIMEOUT_EN is defined.
module mandel_job_host #(
    parameter int N_BIT    = 16,
    parameter int MAX_ITER = 100,
    parameter int TIMEOUT  = 24000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       pix_x,
    input  logic [7:0]       pix_y,
    input  logic [N_BIT-1:0] cxs,
    input  logic [N_BIT-1:0] cys,
    input  logic [N_BIT-1:0] dcx,
    input  logic [N_BIT-1:0] dcy,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    output logic [7:0]       wx,
    output logic [6:0]       wy,
    output logic [1:0]       wd,
    output logic             we
);
    import mandel_pkg::*;

    state_t state_q, state_d;

    logic [0:FRAME_LEN-1][7:0] frame_q, frame_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [7:0] rx_q, rx_d, ry_q, ry_d;
    logic       rx_prev_q;

    logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] wx_q, wx_d;
    logic [6:0] wy_q, wy_d;
    logic [1:0] wd_q, wd_d;
    logic       we_q, we_d;

    logic [1:0] color;
    logic       accept, last_byte, pix_empty, last_ry, last_pix, tmo_hit;

    mandel_color_map #(.MAX_ITER(MAX_ITER)) u_color_map (
        .iter_cnt (rx_data),
        .color    (color)
    );

    // Accept only on a rising rx_ready seen in RECV, so a held level counts once.
    assign accept    = (state_q == ST_RECV) && rx_ready && !rx_prev_q;
    assign last_byte = (idx_q == 4'(FRAME_LEN - 1));
    assign pix_empty = (pix_x_q == 8'd0) || (pix_y_q == 8'd0);
    assign last_ry   = (ry_q == pix_y_q - 8'd1);
    assign last_pix  = last_ry && (rx_q == pix_x_q - 8'd1);

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    assign tmo_hit = (state_q == ST_RECV) && !accept && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        tmo_d = '0;
        if (state_q == ST_RECV && !accept && !tmo_hit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_SEND;
            ST_SEND:    state_d = ST_WAIT_HI;
            ST_WAIT_HI: if (tx_busy) state_d = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (!last_byte)     state_d = ST_SEND;
                    else if (pix_empty) state_d = ST_DONE;
                    else                state_d = ST_RECV;
                end
            end
            ST_RECV:    if ((accept && last_pix) || tmo_hit) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_d = frame_q;
        idx_d   = idx_q;
        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        if (state_q == ST_IDLE && start) begin
            frame_d = {pix_x, pix_y, cxs[15:8], cxs[7:0], cys[15:8], cys[7:0],
                       dcx[15:8], dcx[7:0], dcy[15:8], dcy[7:0]};
            pix_x_d = pix_x;
            pix_y_d = pix_y;
            idx_d   = 4'd0;
            rx_d    = 8'd0;
            ry_d    = 8'd0;
        end
        if (state_q == ST_WAIT_LO && !tx_busy && !last_byte) begin
            idx_d = idx_q + 4'd1;
        end
        // Column-major scan: y runs fastest, x steps when y wraps.
        if (accept) begin
            if (last_ry) begin
                ry_d = 8'd0;
                rx_d = rx_q + 8'd1;
            end else begin
                ry_d = ry_q + 8'd1;
            end
        end
    end

    always_comb begin
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        tx_start_d = (state_d == ST_SEND);
        tx_data_d  = tx_start_d ? frame_d[idx_d] : tx_data_q;
`ifdef RX_TIMEOUT_EN
        err_d = err_q;
        if (state_q == ST_IDLE && start) err_d = 1'b0;
        if (tmo_hit)                     err_d = 1'b1;
`else
        err_d = 1'b0;
`endif
        wx_d = wx_q;
        wy_d = wy_q;
        wd_d = wd_q;
        we_d = 1'b0;
        // Rows past the 128-line framebuffer still consume a byte but never write.
        if (accept) begin
            wx_d = rx_q;
            wy_d = ry_q[6:0];
            wd_d = color;
            we_d = !ry_q[7];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q    <= '0;
            idx_q      <= 4'd0;
            pix_x_q    <= 8'd0;
            pix_y_q    <= 8'd0;
            rx_q       <= 8'd0;
            ry_q       <= 8'd0;
            rx_prev_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            wx_q       <= 8'd0;
            wy_q       <= 7'd0;
            wd_q       <= 2'd0;
            we_q       <= 1'b0;
        end else begin
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            rx_prev_q  <= rx_ready;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            wd_q       <= wd_d;
            we_q       <= we_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign wx       = wx_q;
    assign wy       = wy_q;
    assign wd       = wd_q;
    assign we       = we_q;
endmodule

// File: tb/tb_mandel_job_host.sv
// Randomized scoreboard bench for mandel_job_host with TX8/RX8 behavioural models.
// Timeout scenario is exercised when RX_TIMEOUT_EN is defined.
module tb_mandel_job_host;
    localparam int TX_BUSY = 20;
    localparam int TMO     = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  pix_x = 8'd0, pix_y = 8'd0;
    logic [15:0] cxs = 16'd0, cys = 16'd0, dcx = 16'd0, dcy = 16'd0;
    logic        busy, done, err, tx_start, we;
    logic [7:0]  tx_data, wx;
    logic [6:0]  wy;
    logic [1:0]  wd;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready = 1'b0;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [1:0] d;
    } wr_t;

    int compared = 0, mismatched = 0;
    int tx_cnt = 0, we_cnt = 0, done_cnt = 0, cyc = 0, last_rise_cyc = 0;
    logic [7:0] exp_tx[$];
    wr_t        exp_wr[$];
    int         given_q[$];

    mandel_job_host #(.N_BIT(16), .MAX_ITER(100), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_x(pix_x), .pix_y(pix_y),
        .cxs(cxs), .cys(cys), .dcx(dcx), .dcy(dcy),
        .busy(busy), .done(done), .err(err),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_ready(rx_ready),
        .wx(wx), .wy(wy), .wd(wd), .we(we)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_color(input int b);
        if (b >= 100) return 2'd0;
        if (b % 4 == 0) return 2'd3;
        return 2'(b % 4);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // TX8 model: a tx_start makes the transmitter busy for TX_BUSY cycles.
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            tx_busy = 1'b1;
            repeat (TX_BUSY) @(negedge clk);
            tx_busy = 1'b0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a byte, a write or done.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (tx_start) begin
            tx_cnt++;
            if (exp_tx.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL tx_unexpected: got byte 0x%0h, expected no tx_start", tx_data);
            end else begin
                check("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
            end
        end
        if (we) begin
            we_cnt++;
            if (exp_wr.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL write_unexpected: got (%0d,%0d,%0d), expected no write", wx, wy, wd);
            end else begin
                check("write_xyd", 32'({wx, wy, wd}), 32'(exp_wr.pop_front()));
            end
        end
        if (done) begin
            done_cnt++;
            check("busy_low_at_done", 32'(busy), 32'd0);
        end
    end

    task automatic push_frame(input logic [7:0] px, input logic [7:0] py,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
        exp_tx.push_back(px);
        exp_tx.push_back(py);
        exp_tx.push_back(8'(a >> 8)); exp_tx.push_back(8'(a & 16'hFF));
        exp_tx.push_back(8'(b >> 8)); exp_tx.push_back(8'(b & 16'hFF));
        exp_tx.push_back(8'(c >> 8)); exp_tx.push_back(8'(c & 16'hFF));
        exp_tx.push_back(8'(d >> 8)); exp_tx.push_back(8'(d & 16'hFF));
    endtask

    task automatic pulse_start(input logic [7:0] px, input logic [7:0] py,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d);
        pix_x = px; pix_y = py; cxs = a; cys = b; dcx = c; dcy = d;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic run_job(input logic [7:0] px, input logic [7:0] py,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d,
                           input int nbytes, input int first_hold, input bit noise);
        int total, n, k, base_tx, base_done;
        logic [7:0] v;
        wr_t w;
        total = int'(px) * int'(py);
        n = (nbytes < 0) ? total : nbytes;
        k = 0;
        while (tx_busy && k < 100) begin step(1); k++; end
        base_tx = tx_cnt;
        base_done = done_cnt;
        push_frame(px, py, a, b, c, d);
        pulse_start(px, py, a, b, c, d);
        check("err_clear_on_start", 32'(err), 32'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        // A second start while busy must not disturb the frame in flight.
        step(1);
        pulse_start(8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        k = 0;
        while (tx_cnt < base_tx + 10 && k < 600) begin
            step(1);
            k++;
            if (noise) rx_ready = 1'($urandom);
        end
        rx_ready = 1'b0;
        check("frame_tx_count", 32'(tx_cnt - base_tx), 32'd10);
        k = 0;
        while (tx_busy && k < 100) begin step(1); k++; end
        step(2);
        for (int i = 0; i < n; i++) begin
            if (given_q.size() > 0) v = 8'(given_q.pop_front());
            else                    v = 8'($urandom_range(0, 130));
            if ((i % int'(py)) < 128) begin
                w.x = 8'(i / int'(py));
                w.y = 7'(i % int'(py));
                w.d = ref_color(int'(v));
                exp_wr.push_back(w);
            end
            rx_data = v;
            rx_ready = 1'b1;
            last_rise_cyc = cyc;
            step((i == 0) ? first_hold : int'($urandom_range(1, 3)));
            rx_ready = 1'b0;
            step(int'($urandom_range(1, 3)));
        end
        if (n == total) begin
            k = 0;
            while (done_cnt == base_done && k < 50) begin step(1); k++; end
            step(2);
            check("done_pulses", 32'(done_cnt - base_done), 32'd1);
            check("busy_after_done", 32'(busy), 32'd0);
            check("writes_pending", 32'(exp_wr.size()), 32'd0);
            check("tx_pending", 32'(exp_tx.size()), 32'd0);
        end
    endtask

    initial begin
        int base_we, base_tx, base_done, k;
        logic [7:0] px, py;
        step(3);
        check("reset_outputs", 32'({busy, done, err, tx_start, we, tx_data, wx, wy, wd}), 32'd0);
        rst = 1'b0;
        step(2);
        check("idle_outputs", 32'({busy, done, err, tx_start, we}), 32'd0);

        // Reference job with known bytes, plus rx_ready noise during the frame.
        given_q = '{5, 100, 4, 1, 2, 0};
        base_we = we_cnt;
        run_job(8'd2, 8'd3, 16'hE000, 16'hF000, 16'h0040, 16'h0040, -1, 1, 1'b1);
        check("jobA_writes", 32'(we_cnt - base_we), 32'd6);

        // First byte held high for 50 cycles.
        base_we = we_cnt;
        run_job(8'd1, 8'd3, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), -1, 50, 1'b0);
        check("held_level_writes", 32'(we_cnt - base_we), 32'd3);

        // Empty jobs: frame only.
        base_we = we_cnt;
        run_job(8'd0, 8'd4, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, -1, 1, 1'b1);
        run_job(8'd3, 8'd0, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00, -1, 1, 1'b0);
        check("empty_job_writes", 32'(we_cnt - base_we), 32'd0);

        // Tall column: rows past 127 are consumed without writes.
        base_we = we_cnt;
        run_job(8'd1, 8'd200, 16'hC000, 16'hE800, 16'h0010, 16'h0008, -1, 1, 1'b0);
        check("tall_writes", 32'(we_cnt - base_we), 32'd128);

        for (int j = 0; j < 3; j++) begin
            px = 8'($urandom_range(1, 4));
            py = 8'($urandom_range(1, 6));
            base_we = we_cnt;
            run_job(px, py, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    -1, int'($urandom_range(1, 4)), 1'($urandom));
            check("random_job_writes", 32'(we_cnt - base_we), 32'(int'(px) * int'(py)));
        end

        // Reset while waiting for TX8 to go busy on byte 4.
        k = 0;
        while (tx_busy && k < 100) begin step(1); k++; end
        base_tx = tx_cnt;
        push_frame(8'd3, 8'd4, 16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2);
        pulse_start(8'd3, 8'd4, 16'hA1A2, 16'hB1B2, 16'hC1C2, 16'hD1D2);
        k = 0;
        while (tx_cnt < base_tx + 5 && k < 400) begin step(1); k++; end
        check("pre_reset_tx_count", 32'(tx_cnt - base_tx), 32'd5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_job_reset_outputs", 32'({busy, done, err, tx_start, we, tx_data, wx, wy, wd}), 32'd0);
        step(2);
        rst = 1'b0;
        exp_tx.delete();
        base_tx = tx_cnt;
        base_done = done_cnt;
        step(60);
        check("no_tx_after_reset", 32'(tx_cnt - base_tx), 32'd0);
        check("no_done_after_reset", 32'(done_cnt - base_done), 32'd0);
        check("busy_after_reset", 32'(busy), 32'd0);

        base_we = we_cnt;
        run_job(8'd2, 8'd2, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), -1, 2, 1'b1);
        check("recovery_writes", 32'(we_cnt - base_we), 32'd4);

`ifdef RX_TIMEOUT_EN
        base_we = we_cnt;
        base_done = done_cnt;
        run_job(8'd2, 8'd2, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 3, 1, 1'b0);
        k = 0;
        while (done_cnt == base_done && k < 1200) begin step(1); k++; end
        check("timeout_done", 32'(done_cnt - base_done), 32'd1);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_latency_in_window",
              32'((cyc - last_rise_cyc >= 995) && (cyc - last_rise_cyc <= 1010)), 32'd1);
        check("timeout_writes", 32'(we_cnt - base_we), 32'd3);
        step(3);
        check("err_sticky", 32'(err), 32'd1);
        run_job(8'd1, 8'd2, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), -1, 1, 1'b0);
        check("err_after_clean_job", 32'(err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #600000;
        mismatched++;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mandel_job_host.md
Name: mandel_job_host

Overview:
- Initiator side of the Mandelbrot UART job protocol. It serializes one 10-byte job frame into the byte transmitter, then collects the iteration-count bytes the compute engine returns.
- Each returned count is mapped to a 2-bit colour and written into the video framebuffer write port.
- Sits between a job-issuing controller, the TX8/RX8 byte UART pair, and the video module's wx/wy/wd/we port.

Parameters:
- N_BIT, 16, fixed-point word width of cxs/cys/dcx/dcy (Q12).
- MAX_ITER, 100, iteration count the engine reports for in-set points.
- TIMEOUT, 24000000, idle-cycle limit between result bytes (used only with the optional feature).

Ports:
- clk  in  1  system clock (24 MHz domain)
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle job request; sampled only in IDLE
- pix_x  in  8  columns in job
- pix_y  in  8  rows in job
- cxs  in  N_BIT  start real coordinate
- cys  in  N_BIT  start imaginary coordinate
- dcx  in  N_BIT  real step
- dcy  in  N_BIT  imaginary step
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at job completion
- err  out  1  sticky timeout flag; cleared by next accepted start
- tx_data  out  8  byte to TX8
- tx_start  out  1  one-cycle send request to TX8
- tx_busy  in  1  TX8 busy
- rx_data  in  8  byte from RX8
- rx_ready  in  1  RX8 byte-valid level
- wx  out  8  framebuffer write X
- wy  out  7  framebuffer write Y
- wd  out  2  framebuffer write colour
- we  out  1  framebuffer write enable, one-cycle pulse

Behaviour:
- Reset values: busy, done, err, tx_start, we = 0; tx_data, wx, wy, wd = 0; state = IDLE.
- Reset asserted mid-job aborts immediately; no further tx_start or we is issued.
- start pulse in IDLE:
  - Latches all job inputs into a 10-byte frame.
  - Frame order: pix_x, pix_y, cxs[15:8], cxs[7:0], cys[15:8], cys[7:0], dcx[15:8], dcx[7:0], dcy[15:8], dcy[7:0].
  - Clears err and the result counters; busy=1 the next cycle.
- start while busy is ignored.
- States: IDLE -> SEND -> WAIT_HI -> WAIT_LO -> (SEND | RECV) -> DONE -> IDLE.
  - SEND: drive tx_data with the current frame byte; tx_start=1 for exactly one cycle.
  - WAIT_HI: wait for tx_busy=1.
  - WAIT_LO: wait for tx_busy=0. Then advance the byte index; after byte 9 go to RECV.
- Result receive:
  - A byte is accepted on a rx_ready 0->1 edge, using a registered previous value.
  - A byte is accepted only in RECV; edges in any other state are discarded.
  - rx_ready held high produces exactly one accept.
- Pixel order: y fastest.
  - Counters ry 0..pix_y-1 and rx 0..pix_x-1.
  - After ry = pix_y-1, ry wraps to 0 and rx increments.
  - After the pixel at (pix_x-1, pix_y-1) is accepted, go to DONE.
- Write latency: wx=rx[7:0], wy=ry[6:0], wd, and we=1 are registered one cycle after the accept edge.
  - we is suppressed when ry >= 128; the counter still advances.
- Colour mapping:
  - byte >= MAX_ITER -> wd=0 (black).
  - Otherwise wd = byte[1:0], except byte[1:0]=0 -> wd=3.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- pix_x=0 or pix_y=0: the frame is still sent, then go straight from SEND completion to DONE with no writes.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- When defined:
  - A counter runs in RECV and resets on every accepted byte.
  - On reaching TIMEOUT-1, set err=1, pulse done, go to IDLE.
- When undefined: no counter; err is tied 0; RECV waits indefinitely.

Decomposition:
- Shared package mandel_pkg:
  - N_BIT, BIT_FRAC (12), FRAME_LEN (10).
  - State encoding typedef.
  - Colour-map constant COLOR_INSET (2'd0).
- One natural sub-module, mandel_color_map: combinational byte -> wd with the MAX_ITER parameter.

Test Plan:
- pix_x=2, pix_y=3, cxs=0xE000, cys=0xF000, dcx=0x0040, dcy=0x0040, TX8 model busy 20 cycles:
  - tx_data sequence 02 03 E0 00 F0 00 00 40 00 40.
  - Exactly 10 tx_start pulses.
- Same job, RX model returns bytes 5,100,4,1,2,0:
  - Writes (0,0,1) (0,1,0) (0,2,3) (1,0,1) (1,1,2) (1,2,3).
  - done pulses once; busy falls.
- rx_ready held high 50 cycles in RECV, and edges during SEND:
  - One write for the held level; edges during SEND produce no write.
- pix_y=200, pix_x=1, 200 bytes:
  - 128 we pulses for ry 0..127; none for 128..199; done asserted.
- rst asserted during WAIT_HI of byte 4:
  - All outputs 0 next edge; no tx_start until a new start.
  - start during busy is ignored.
- RX_TIMEOUT_EN with TIMEOUT=1000, stop RX after 3 bytes:
  - err=1 and a done pulse at 1000 idle cycles; next start clears err.
